maple_in: RTL and testbench

- Receive-side deserializer for the Maple bus.
- Sits downstream of the port multiplexer's in_p1/in_p5 outputs and upstream of the read FIFO.
- Detects the START pattern, decodes alternating-clock data bits into bytes, detects the END pattern, and pushes bytes to the FIFO.
- Driven by the register file through REG_INCTRL (enable, status, error clear).

---
 rtl/maple_pkg.sv | 28 ++
 rtl/maple_in_sync.sv | 48 ++++
 rtl/maple_in.sv | 212 +++++++++++++++++++++
 tb/tb_maple_in.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// Shared types and constants for the Maple bus receive path.
package maple_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    END   = 2'd3
  } maple_state_e;

  // B pulses inside START and A pulses inside END for a well-formed frame
  localparam int unsigned START_PULSES = 4;
  localparam int unsigned END_PULSES   = 2;

  // REG_INCTRL bit positions
  localparam int unsigned INCTRL_ENABLE       = 0;
  localparam int unsigned INCTRL_BUSY         = 1;
  localparam int unsigned INCTRL_ERR_PROTOCOL = 2;
  localparam int unsigned INCTRL_ERR_TIMEOUT  = 3;
  localparam int unsigned INCTRL_ERR_OVERFLOW = 4;
  localparam int unsigned INCTRL_CLEAR_ERRORS = 5;

  // Pulse counter increment that sticks at 7
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/maple_in_sync.sv
// Per-line synchronizer and edge detector; outputs are registered so that
// level, fall and rise of both lines stay aligned to the same cycle.
module maple_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta_q, sync_q, prev_q, level_q, fall_q, rise_q;
  logic meta_d, sync_d, prev_d, level_d, fall_d, rise_d;

  // Next values for the synchronizer chain and edge flags
  always_comb begin
    meta_d  = pin;
    sync_d  = meta_q;
    prev_d  = sync_q;
    level_d = sync_q;
    fall_d  = prev_q & ~sync_q;
    rise_d  = ~prev_q & sync_q;
  end

  // Chain registers; preset high so reset looks like an idle bus
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;
  assign rise  = rise_q;

endmodule

// File: rtl/maple_in.sv
// Maple bus receive deserializer: START detect, alternating-clock bit decode,
// END detect, byte push to the read FIFO with sticky error reporting.
module maple_in
  import maple_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_p1,
  input  logic       in_p5,
  input  logic       enable,
  input  logic       tick,
  input  logic       clear_errors,
  input  logic       fifo_ready,
  output logic [7:0] data_out,
  output logic       data_strobe,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy,
  output logic       err_protocol,
  output logic       err_timeout,
  output logic       err_overflow
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_TICKS);

  logic a_lvl, a_fall, a_rise, b_lvl, b_fall, b_rise;

  maple_in_sync u_sync_a (.clk(clk), .rst(rst), .pin(in_p1), .level(a_lvl), .fall(a_fall), .rise(a_rise));
  maple_in_sync u_sync_b (.clk(clk), .rst(rst), .pin(in_p5), .level(b_lvl), .fall(b_fall), .rise(b_rise));

  maple_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         phase_b_q, phase_b_d;
  logic [2:0]   bitcnt_q, bitcnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [15:0]  timer_q, timer_d;

  logic [7:0] data_out_q, data_out_d;
  logic       data_strobe_q, data_strobe_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_end_q, frame_end_d;
  logic       busy_q, busy_d;
  logic       err_protocol_q, err_protocol_d;
  logic       err_timeout_q, err_timeout_d;
  logic       err_overflow_q, err_overflow_d;

  logic       ev_start, ev_end, ev_byte, ev_perr, ev_tout;
  logic       do_shift, bit_in, any_edge, both_edge;
  logic [7:0] byte_val;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      phase_b_q      <= 1'b0;
      bitcnt_q       <= '0;
      shreg_q        <= '0;
      timer_q        <= '0;
      data_out_q     <= '0;
      data_strobe_q  <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_protocol_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      phase_b_q      <= phase_b_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      timer_q        <= timer_d;
      data_out_q     <= data_out_d;
      data_strobe_q  <= data_strobe_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      busy_q         <= busy_d;
      err_protocol_q <= err_protocol_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // Next-state logic: frame decode, abort conditions and event generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_b_d = phase_b_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    ev_start  = 1'b0;
    ev_end    = 1'b0;
    ev_byte   = 1'b0;
    ev_perr   = 1'b0;
    ev_tout   = 1'b0;
    do_shift  = 1'b0;
    bit_in    = 1'b0;
    byte_val  = '0;
    any_edge  = a_fall | a_rise | b_fall | b_rise;
    both_edge = (a_fall | a_rise) & (b_fall | b_rise);

    if (state_q == IDLE || any_edge) timer_d = '0;
    else if (tick)                   timer_d = timer_q + 16'd1;
    else                             timer_d = timer_q;

    // Aborts take priority over the per-state decode below
    if (state_q != IDLE && !enable) begin
      state_d = IDLE;
    end else if (state_q != IDLE && both_edge) begin
      ev_perr = 1'b1;
      state_d = IDLE;
    end else if (state_q != IDLE && timer_d == TO_LIMIT) begin
      ev_tout = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_fall && b_lvl && enable) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (a_rise) begin
            if (cnt_q == 3'(START_PULSES)) begin
              state_d   = DATA;
              phase_b_d = 1'b0;
              bitcnt_d  = '0;
              ev_start  = 1'b1;
            end else begin
              ev_perr = 1'b1;
              state_d = IDLE;
            end
          end else if (b_fall && !a_lvl) begin
            cnt_d = sat_inc3(cnt_q);
          end
        end
        DATA: begin
          if (!phase_b_q) begin
            if (a_fall) begin
              do_shift  = 1'b1;
              bit_in    = b_lvl;
              phase_b_d = 1'b1;
            end else if (b_fall && a_lvl) begin
              if (bitcnt_q == 3'd0) begin
                state_d = END;
                cnt_d   = '0;
              end else begin
                ev_perr = 1'b1;
                state_d = IDLE;
              end
            end
          end else begin
            if (b_fall) begin
              do_shift  = 1'b1;
              bit_in    = a_lvl;
              phase_b_d = 1'b0;
            end else if (a_fall) begin
              ev_perr = 1'b1;
              state_d = IDLE;
            end
          end
        end
        END: begin
          if (b_rise) begin
            if (cnt_q == 3'(END_PULSES)) ev_end = 1'b1;
            else                         ev_perr = 1'b1;
            state_d = IDLE;
          end else if (a_fall && !b_lvl) begin
            cnt_d = sat_inc3(cnt_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_shift) begin
      shreg_d  = {shreg_q[6:0], bit_in};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        ev_byte  = 1'b1;
        byte_val = {shreg_q[6:0], bit_in};
      end
    end
  end

  // Output logic: registered pulses, byte load and sticky flags (set beats clear)
  always_comb begin
    data_out_d     = ev_byte ? byte_val : data_out_q;
    data_strobe_d  = ev_byte & fifo_ready;
    frame_start_d  = ev_start;
    frame_end_d    = ev_end;
    busy_d         = (state_d != IDLE);
    err_protocol_d = (err_protocol_q & ~clear_errors) | ev_perr;
    err_timeout_d  = (err_timeout_q & ~clear_errors) | ev_tout;
    err_overflow_d = (err_overflow_q & ~clear_errors) | (ev_byte & ~fifo_ready);
  end

  assign data_out     = data_out_q;
  assign data_strobe  = data_strobe_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign busy         = busy_q;
  assign err_protocol = err_protocol_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_maple_in.sv
// Directed bench for maple_in: frame table plus hand-written corner cases.
module tb_maple_in;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_p1 = 1'b1;
  logic       in_p5 = 1'b1;
  logic       enable = 1'b1;
  logic       tick = 1'b0;
  logic       clear_errors = 1'b0;
  logic       fifo_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_strobe, frame_start, frame_end, busy;
  logic       err_protocol, err_timeout, err_overflow;

  localparam bit LA = 1'b0;
  localparam bit LB = 1'b1;

  maple_in #(.TIMEOUT_TICKS(5)) dut (
    .clk(clk), .rst(rst), .in_p1(in_p1), .in_p5(in_p5), .enable(enable),
    .tick(tick), .clear_errors(clear_errors), .fifo_ready(fifo_ready),
    .data_out(data_out), .data_strobe(data_strobe), .frame_start(frame_start),
    .frame_end(frame_end), .busy(busy), .err_protocol(err_protocol),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Event monitor: counts pulses and captures every strobed byte
  int n_ds = 0, n_fs = 0, n_fe = 0;
  logic [7:0] cap [0:255];
  always @(negedge clk) begin
    if (data_strobe) begin
      cap[n_ds[7:0]] = data_out;
      n_ds++;
    end
    if (frame_start) n_fs++;
    if (frame_end) n_fe++;
  end

  typedef struct {
    int         np;
    int         nb;
    logic [7:0] b0, b1;
    int         pb;
    logic [7:0] pval;
    bit         do_end;
    bit         rdy1;
    int         e_fs, e_ds, e_fe;
    bit         e_ep, e_eo;
    logic [7:0] e_d0, e_d1;
  } vec_t;

  vec_t vt [0:7];
  bit   ph;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit line, input logic v, input int sel, output int lat);
    lat = 99;
    @(negedge clk);
    if (line) in_p5 = v; else in_p1 = v;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (lat == 99) begin
        case (sel)
          0: if (frame_start) lat = k;
          1: if (data_strobe) lat = k;
          2: if (frame_end) lat = k;
          default: ;
        endcase
      end
    end
  endtask

  task automatic pin(input bit line, input logic v);
    int l;
    drive(line, v, -1, l);
  endtask

  task automatic send_bit(input logic v);
    if (!ph) begin pin(LB, v); pin(LA, 1'b1); pin(LA, 1'b0); ph = 1'b1; end
    else     begin pin(LA, v); pin(LB, 1'b1); pin(LB, 1'b0); ph = 1'b0; end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  task automatic send_start(input int np);
    pin(LA, 1'b0);
    for (int i = 0; i < np; i++) begin
      pin(LB, 1'b0);
      if (i != np - 1) pin(LB, 1'b1);
    end
    pin(LA, 1'b1);
    ph = 1'b0;
  endtask

  task automatic send_end();
    pin(LA, 1'b1); pin(LB, 1'b1); pin(LB, 1'b0);
    pin(LA, 1'b0); pin(LA, 1'b1); pin(LA, 1'b0); pin(LA, 1'b1);
    pin(LB, 1'b1);
  endtask

  task automatic idle_lines();
    pin(LA, 1'b1);
    pin(LB, 1'b1);
    repeat (4) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear_errors = 1'b1;
    @(negedge clk) clear_errors = 1'b0;
  endtask

  initial begin
    int ds0, fs0, fe0, lat;

    vt[0] = '{4, 2, 8'hA5, 8'h3C, 0, 8'h00, 1'b1, 1'b1, 1, 2, 1, 1'b0, 1'b0, 8'hA5, 8'h3C};
    vt[1] = '{3, 0, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00};
    vt[2] = '{4, 2, 8'h5A, 8'hC3, 0, 8'h00, 1'b1, 1'b1, 1, 2, 1, 1'b0, 1'b0, 8'h5A, 8'hC3};
    vt[3] = '{4, 2, 8'h11, 8'h22, 0, 8'h00, 1'b1, 1'b0, 1, 1, 1, 1'b0, 1'b1, 8'h11, 8'h00};
    vt[4] = '{4, 0, 8'h00, 8'h00, 4, 8'hB0, 1'b1, 1'b1, 1, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00};
    vt[5] = '{4, 2, 8'h00, 8'hFF, 0, 8'h00, 1'b1, 1'b1, 1, 2, 1, 1'b0, 1'b0, 8'h00, 8'hFF};
    vt[6] = '{5, 0, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00};
    vt[7] = '{4, 1, 8'h80, 8'h00, 0, 8'h00, 1'b1, 1'b1, 1, 1, 1, 1'b0, 1'b0, 8'h80, 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst data_out", 32'(data_out), 32'h0);
    chk("rst data_strobe", 32'(data_strobe), 32'h0);
    chk("rst frame_start", 32'(frame_start), 32'h0);
    chk("rst frame_end", 32'(frame_end), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst err_protocol", 32'(err_protocol), 32'h0);
    chk("rst err_timeout", 32'(err_timeout), 32'h0);
    chk("rst err_overflow", 32'(err_overflow), 32'h0);
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // Frame table
    for (int i = 0; i < 8; i++) begin
      pulse_clear();
      fifo_ready = 1'b1;
      ds0 = n_ds; fs0 = n_fs; fe0 = n_fe;
      send_start(vt[i].np);
      if (vt[i].np == 4) begin
        for (int j = 0; j < vt[i].nb; j++) begin
          fifo_ready = (j == 1) ? vt[i].rdy1 : 1'b1;
          send_bits((j == 0) ? vt[i].b0 : vt[i].b1, 8);
        end
        fifo_ready = 1'b1;
        if (vt[i].pb > 0) send_bits(vt[i].pval, vt[i].pb);
        if (vt[i].do_end) send_end();
      end
      idle_lines();
      chk($sformatf("v%0d frame_start count", i), 32'(n_fs - fs0), 32'(vt[i].e_fs));
      chk($sformatf("v%0d data_strobe count", i), 32'(n_ds - ds0), 32'(vt[i].e_ds));
      chk($sformatf("v%0d frame_end count", i), 32'(n_fe - fe0), 32'(vt[i].e_fe));
      chk($sformatf("v%0d err_protocol", i), 32'(err_protocol), 32'(vt[i].e_ep));
      chk($sformatf("v%0d err_overflow", i), 32'(err_overflow), 32'(vt[i].e_eo));
      chk($sformatf("v%0d err_timeout", i), 32'(err_timeout), 32'h0);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'h0);
      if (vt[i].e_ds > 0) chk($sformatf("v%0d byte0", i), 32'(cap[ds0[7:0]]), 32'(vt[i].e_d0));
      if (vt[i].e_ds > 1) chk($sformatf("v%0d byte1", i), 32'(cap[8'(ds0 + 1)]), 32'(vt[i].e_d1));
    end

    // Overflow flag is cleared by clear_errors
    chk("ovf before clear", 32'(err_overflow), 32'h0);
    send_start(4);
    fifo_ready = 1'b0;
    send_bits(8'h11, 8);
    fifo_ready = 1'b1;
    send_end();
    idle_lines();
    chk("ovf set", 32'(err_overflow), 32'h1);
    pulse_clear();
    @(posedge clk); #1;
    chk("ovf cleared", 32'(err_overflow), 32'h0);

    // Latency of frame_start, data_strobe and frame_end from the causing pin edge
    ds0 = n_ds;
    pin(LA, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pin(LB, 1'b0);
      if (i != 3) pin(LB, 1'b1);
    end
    drive(LA, 1'b1, 0, lat);
    chk("latency frame_start", 32'(lat), 32'd4);
    ph = 1'b0;
    send_bits(8'hC3, 7);
    pin(LA, 1'b1); pin(LB, 1'b1);
    drive(LB, 1'b0, 1, lat);
    chk("latency data_strobe", 32'(lat), 32'd4);
    chk("latency byte", 32'(cap[ds0[7:0]]), 32'h0C3);
    pin(LA, 1'b1); pin(LB, 1'b1); pin(LB, 1'b0);
    pin(LA, 1'b0); pin(LA, 1'b1); pin(LA, 1'b0); pin(LA, 1'b1);
    drive(LB, 1'b1, 2, lat);
    chk("latency frame_end", 32'(lat), 32'd4);
    idle_lines();

    // Stall timeout after 3 data bits, tick every cycle
    pulse_clear();
    ds0 = n_ds;
    send_start(4);
    send_bits(8'hA0, 3);
    chk("tout busy before", 32'(busy), 32'h1);
    @(negedge clk) tick = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("tout not yet", 32'(err_timeout), 32'h0);
    chk("tout busy at 4 ticks", 32'(busy), 32'h1);
    @(posedge clk); #1;
    chk("tout set", 32'(err_timeout), 32'h1);
    chk("tout busy after", 32'(busy), 32'h0);
    @(negedge clk) tick = 1'b0;
    idle_lines();
    chk("tout no strobe", 32'(n_ds - ds0), 32'h0);
    chk("tout err_protocol", 32'(err_protocol), 32'h0);

    // Reset mid-byte
    pulse_clear();
    send_start(4);
    send_bits(8'hA0, 4);
    ds0 = n_ds; fe0 = n_fe;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst data_out", 32'(data_out), 32'h0);
    chk("midrst strobe", 32'(data_strobe), 32'h0);
    chk("midrst errors", 32'({err_protocol, err_timeout, err_overflow}), 32'h0);
    @(negedge clk) rst = 1'b0;
    idle_lines();
    chk("midrst no strobe", 32'(n_ds - ds0), 32'h0);
    chk("midrst no frame_end", 32'(n_fe - fe0), 32'h0);
    chk("midrst busy idle", 32'(busy), 32'h0);

    // enable dropped mid-byte
    send_start(4);
    send_bits(8'h5F, 4);
    chk("endis busy before", 32'(busy), 32'h1);
    ds0 = n_ds; fe0 = n_fe;
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    chk("endis busy", 32'(busy), 32'h0);
    chk("endis errors", 32'({err_protocol, err_timeout, err_overflow}), 32'h0);
    idle_lines();
    @(negedge clk) enable = 1'b1;
    repeat (4) @(posedge clk);
    chk("endis no strobe", 32'(n_ds - ds0), 32'h0);
    chk("endis no frame_end", 32'(n_fe - fe0), 32'h0);
    chk("endis errors after", 32'({err_protocol, err_timeout, err_overflow}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
